// File: rtl/hyperram_init_sequencer.sv
`timescale 1ns/1ps
// HyperRAM command sequencer: power-up wait, HW reset, CR write and ID read, then
// single host memory ops; every op is watchdog-guarded with bounded sequence retry.
module hyperram_init_sequencer #(
    parameter int POWERUP_CYCLES = 15000,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 2,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       iClk,
    input  logic       iRstN,
    output logic       oCtrlEn,
    output logic [2:0] oCtrlOpReq,
    input  logic       iCtrlOpDone,
    input  logic       iHostValid,
    input  logic [2:0] iHostOp,
    output logic       oHostReady,
    output logic       oHostDone,
    output logic       oHostErr,
    input  logic       iReinit,
    output logic       oInitDone,
    output logic       oInitFail,
    output logic [1:0] oRetryCnt,
    output logic [3:0] oState
);

    typedef enum logic [3:0] {
        PWRUP = 4'd0,
        RST   = 4'd1,
        WCFG  = 4'd2,
        RDID  = 4'd3,
        GAP   = 4'd4,
        READY = 4'd5,
        HOST  = 4'd6,
        FAIL  = 4'd7
    } seqStateT;

    localparam logic [2:0] OP_HWRST = 3'b000;
    localparam logic [2:0] OP_RDREG = 3'b001;
    localparam logic [2:0] OP_WRREG = 3'b010;
    localparam logic [2:0] OP_RDMEM = 3'b011;
    localparam logic [2:0] OP_WRMEM = 3'b100;

    localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] PWR_LAST  = PW'(POWERUP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [15:0]   WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

    seqStateT      state;
    seqStateT      succ;
    logic [PW-1:0] pwrCnt;
    logic [15:0]   wdogCnt;
    logic [GW-1:0] gapCnt;
    logic          hostLegal;

    // Op code driven on entry to each bring-up op state.
    function automatic logic [2:0] stateOp(input seqStateT s);
        logic [2:0] op;
        case (s)
            WCFG:    op = OP_WRREG;
            RDID:    op = OP_RDREG;
            default: op = OP_HWRST;
        endcase
        return op;
    endfunction

    // State entered once the inter-op gap after a completed op has elapsed.
    function automatic seqStateT gapSucc(input seqStateT s);
        seqStateT n;
        case (s)
            RST:     n = WCFG;
            WCFG:    n = RDID;
            default: n = READY;
        endcase
        return n;
    endfunction

    assign oState = state;

    // Host handshake qualification; a reinit in the same cycle takes priority.
    always_comb begin
        if ((state == READY) && !iReinit) begin
            oHostReady = 1'b1;
        end else begin
            oHostReady = 1'b0;
        end
        hostLegal = (iHostOp == OP_RDMEM) || (iHostOp == OP_WRMEM);
    end

    // Sequencer FSM with registered op-port, host-status and bring-up outputs.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state      <= PWRUP;
            succ       <= PWRUP;
            pwrCnt     <= '0;
            wdogCnt    <= 16'd0;
            gapCnt     <= '0;
            oCtrlEn    <= 1'b0;
            oCtrlOpReq <= OP_HWRST;
            oHostDone  <= 1'b0;
            oHostErr   <= 1'b0;
            oInitDone  <= 1'b0;
            oInitFail  <= 1'b0;
            oRetryCnt  <= 2'd0;
        end else begin
            oHostDone <= 1'b0;
            oHostErr  <= 1'b0;
            case (state)
                PWRUP: begin
                    if (pwrCnt == PWR_LAST) begin
                        state      <= RST;
                        oCtrlEn    <= 1'b1;
                        oCtrlOpReq <= OP_HWRST;
                        wdogCnt    <= 16'd0;
                    end else begin
                        pwrCnt <= pwrCnt + PW'(1);
                    end
                end
                RST, WCFG, RDID, HOST: begin
                    // Done has priority over a watchdog expiry in the same cycle.
                    if (iCtrlOpDone) begin
                        oCtrlEn <= 1'b0;
                        state   <= GAP;
                        gapCnt  <= '0;
                        succ    <= gapSucc(state);
                        if (state == HOST) begin
                            oHostDone <= 1'b1;
                        end else begin
                            oHostDone <= 1'b0;
                        end
                    end else if (wdogCnt == WDOG_LAST) begin
                        if (state == HOST) begin
                            oHostDone  <= 1'b1;
                            oHostErr   <= 1'b1;
                            oRetryCnt  <= 2'd0;
                            oInitDone  <= 1'b0;
                            state      <= RST;
                            oCtrlOpReq <= OP_HWRST;
                            wdogCnt    <= 16'd0;
                        end else if (oRetryCnt == RETRY_MAX) begin
                            state      <= FAIL;
                            oCtrlEn    <= 1'b0;
                            oCtrlOpReq <= OP_HWRST;
                            oInitFail  <= 1'b1;
                        end else begin
                            // Enable stays high: op 000 pulls the engine back to idle.
                            oRetryCnt  <= oRetryCnt + 2'd1;
                            state      <= RST;
                            oCtrlOpReq <= OP_HWRST;
                            wdogCnt    <= 16'd0;
                        end
                    end else begin
                        wdogCnt <= wdogCnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        state <= succ;
                        if (succ == READY) begin
                            oInitDone <= 1'b1;
                        end else begin
                            oCtrlEn    <= 1'b1;
                            oCtrlOpReq <= stateOp(succ);
                            wdogCnt    <= 16'd0;
                        end
                    end else begin
                        gapCnt <= gapCnt + GW'(1);
                    end
                end
                READY: begin
                    if (iReinit) begin
                        oRetryCnt  <= 2'd0;
                        oInitDone  <= 1'b0;
                        oInitFail  <= 1'b0;
                        state      <= RST;
                        oCtrlEn    <= 1'b1;
                        oCtrlOpReq <= OP_HWRST;
                        wdogCnt    <= 16'd0;
                    end else if (iHostValid && oHostReady) begin
                        if (hostLegal) begin
                            state      <= HOST;
                            oCtrlEn    <= 1'b1;
                            oCtrlOpReq <= iHostOp;
                            wdogCnt    <= 16'd0;
                        end else begin
                            oHostDone <= 1'b1;
                            oHostErr  <= 1'b1;
                        end
                    end else begin
                        state <= READY;
                    end
                end
                FAIL: begin
                    if (iReinit) begin
                        oRetryCnt  <= 2'd0;
                        oInitDone  <= 1'b0;
                        oInitFail  <= 1'b0;
                        state      <= RST;
                        oCtrlEn    <= 1'b1;
                        oCtrlOpReq <= OP_HWRST;
                        wdogCnt    <= 16'd0;
                    end else begin
                        oCtrlEn    <= 1'b0;
                        oCtrlOpReq <= OP_HWRST;
                        oInitFail  <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encodings park safely in FAIL with the port idle.
                    state      <= FAIL;
                    oCtrlEn    <= 1'b0;
                    oCtrlOpReq <= OP_HWRST;
                    oInitFail  <= 1'b1;
                end
            endcase
        end
    end

endmodule
